ap_ctrl_chain_driver: RTL and testbench

- Synthesizable initiator for the ap_ctrl_chain block-level handshake: drives ap_start/ap_continue into an HLS-generated kernel and consumes ap_ready/ap_done.
- Issues a programmed number of transactions with a configurable inter-start gap and configurable ap_continue backpressure.
- Measures per-transaction latency (min/max/last) and total run cycles.
- Used in on-chip kernel self-test wrappers and as the stimulus counterpart to the simulation-side module status monitors.

---
 rtl/ap_ctrl_chain_driver.sv | 207 ++++++++++++++++++++
 tb/tb_ap_ctrl_chain_driver.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain initiator: issues a programmed number of kernel starts with an
// optional inter-start gap, applies ap_continue backpressure, and records
// per-transaction latency statistics plus the total run length.
module ap_ctrl_chain_driver #(
    parameter int CNT_W   = 32,
    parameter int TXN_W   = 16,
    parameter int MAX_OUT = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cfg_start,
    input  logic [TXN_W-1:0] cfg_num_txn,
    input  logic [7:0]       cfg_gap,
    input  logic [7:0]       cfg_cont_hold,
    output logic             dut_ap_start,
    output logic             dut_ap_continue,
    input  logic             dut_ap_ready,
    input  logic             dut_ap_done,
    output logic             busy,
    output logic             run_done,
    output logic [TXN_W-1:0] txn_issued,
    output logic [TXN_W-1:0] txn_completed,
    output logic [CNT_W-1:0] last_latency,
    output logic [CNT_W-1:0] min_latency,
    output logic [CNT_W-1:0] max_latency,
    output logic [CNT_W-1:0] total_cycles
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GAP   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state;
    logic [TXN_W-1:0] num_r;
    logic [7:0]       gap_r;
    logic [7:0]       hold_r;
    logic [7:0]       gap_cnt;
    logic             stamped;      // current start already has a timestamp
    logic [CNT_W-1:0] cycle_ctr;
    logic [CNT_W-1:0] start_stamp;

    logic [CNT_W-1:0] ts_mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic             hold_act;     // a done is seen and awaiting continue
    logic [7:0]       hold_cnt;

    logic             accept;
    logic             start_w;
    logic             push;
    logic             rdy_hs;
    logic             cont_w;
    logic             done_hs;
    logic             pop;
    logic             more_txn;
    logic [CNT_W-1:0] cur_lat;

    // Start is gated by occupancy only until it is raised; after that it
    // holds until ready so the kernel never sees a withdrawn start.
    assign accept   = cfg_start && (state == S_IDLE);
    assign start_w  = (state == S_ISSUE) && (stamped || (occ < OCC_W'(MAX_OUT)));
    assign push     = start_w && !stamped;
    assign rdy_hs   = start_w && dut_ap_ready;
    assign cont_w   = busy && dut_ap_done && (hold_act ? (hold_cnt == 8'd0) : (hold_r == 8'd0));
    assign done_hs  = cont_w;
    assign pop      = done_hs && (occ != '0);
    assign more_txn = ({1'b0, txn_issued} + {{TXN_W{1'b0}}, 1'b1}) < {1'b0, num_r};
    assign cur_lat  = cycle_ctr - ts_mem[rd_ptr];

    assign dut_ap_start    = start_w;
    assign dut_ap_continue = cont_w;

    // Issue sequencing: idle -> issue -> (gap -> issue)* -> drain -> idle.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            stamped      <= 1'b0;
            gap_cnt      <= 8'd0;
            num_r        <= '0;
            gap_r        <= 8'd0;
            hold_r       <= 8'd0;
            total_cycles <= '0;
        end else begin
            run_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        num_r        <= cfg_num_txn;
                        gap_r        <= cfg_gap;
                        hold_r       <= cfg_cont_hold;
                        stamped      <= 1'b0;
                        start_stamp  <= cycle_ctr;
                        if (cfg_num_txn == '0) begin
                            run_done     <= 1'b1;
                            total_cycles <= CNT_W'(1);
                        end else begin
                            busy         <= 1'b1;
                            total_cycles <= '0;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 8'd0) state <= S_ISSUE;
                    else gap_cnt <= gap_cnt - 8'd1;
                end
                S_ISSUE: begin
                    if (push && !dut_ap_ready) stamped <= 1'b1;
                    if (rdy_hs) begin
                        stamped <= 1'b0;
                        if (more_txn) begin
                            if (gap_r != 8'd0) begin
                                state   <= S_GAP;
                                gap_cnt <= gap_r - 8'd1;
                            end
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (txn_completed >= num_r) begin
                        run_done     <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                        total_cycles <= cycle_ctr + CNT_W'(1) - start_stamp;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Run timebase: advances on the accepting cycle and every busy cycle.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) cycle_ctr <= '0;
        else if (busy || accept) cycle_ctr <= cycle_ctr + CNT_W'(1);
    end

    // Timestamp FIFO pointers and occupancy (outstanding transactions).
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || accept) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Timestamp storage; contents are meaningful only below occupancy.
    always_ff @(posedge ap_clk) begin
        if (push) ts_mem[wr_ptr] <= cycle_ctr;
    end

    // Continue backpressure: count down the hold once per observed done.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            hold_act <= 1'b0;
            hold_cnt <= 8'd0;
        end else if (accept || !busy || done_hs) begin
            hold_act <= 1'b0;
        end else if (dut_ap_done && !hold_act) begin
            hold_act <= 1'b1;
            hold_cnt <= hold_r - 8'd1;
        end else if (hold_act && (hold_cnt != 8'd0)) begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end

    // Handshake counters and latency statistics; an empty FIFO on done
    // still counts the completion but leaves the latency figures alone.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || accept) begin
            txn_issued    <= '0;
            txn_completed <= '0;
            last_latency  <= '0;
            min_latency   <= '1;
            max_latency   <= '0;
        end else begin
            if (rdy_hs) txn_issued <= txn_issued + TXN_W'(1);
            if (done_hs) begin
                txn_completed <= txn_completed + TXN_W'(1);
                if (pop) begin
                    last_latency <= cur_lat;
                    if (cur_lat < min_latency) min_latency <= cur_lat;
                    if (cur_lat > max_latency) max_latency <= cur_lat;
                end
            end
        end
    end

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Bench for ap_ctrl_chain_driver: an emulated pipelined kernel, a
// transaction-level reference model checked every cycle, and directed runs
// with hand-derived final figures.
module tb_ap_ctrl_chain_driver;

    localparam int MAX_OUT = 4;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        cfg_start;
    logic [15:0] cfg_num_txn;
    logic [7:0]  cfg_gap;
    logic [7:0]  cfg_cont_hold;
    logic        dut_ap_start;
    logic        dut_ap_continue;
    logic        dut_ap_ready;
    logic        dut_ap_done;
    logic        busy;
    logic        run_done;
    logic [15:0] txn_issued;
    logic [15:0] txn_completed;
    logic [31:0] last_latency;
    logic [31:0] min_latency;
    logic [31:0] max_latency;
    logic [31:0] total_cycles;

    ap_ctrl_chain_driver #(.CNT_W(32), .TXN_W(16), .MAX_OUT(MAX_OUT)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_start(cfg_start),
        .cfg_num_txn(cfg_num_txn), .cfg_gap(cfg_gap), .cfg_cont_hold(cfg_cont_hold),
        .dut_ap_start(dut_ap_start), .dut_ap_continue(dut_ap_continue),
        .dut_ap_ready(dut_ap_ready), .dut_ap_done(dut_ap_done),
        .busy(busy), .run_done(run_done), .txn_issued(txn_issued),
        .txn_completed(txn_completed), .last_latency(last_latency),
        .min_latency(min_latency), .max_latency(max_latency),
        .total_cycles(total_cycles)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit mon_en = 0;

    // Kernel emulation: ready in the start cycle, done klat cycles after
    // ready, completions in order, done not before withhold_until.
    int   klat = 1;
    int   withhold_until = 0;
    logic done_drv;
    int   kq[$];

    assign dut_ap_ready = dut_ap_start;
    assign dut_ap_done  = done_drv;

    // Observation counters, cleared by the stimulus at each run start.
    int n_start_cyc = 0;
    int n_cont_cyc = 0;
    int n_rd = 0;

    // Reference model state (cycle indices, not DUT counter values).
    int          m_active = 0, m_num = 0, m_gap = 0, m_hold = 0;
    int          m_issued = 0, m_completed = 0, m_pending = 0, m_earliest = 0;
    int          m_ack = 0, m_done_first = 0, m_rd = -1, m_start_cyc = 0;
    int          stq[$];
    logic [31:0] m_last = '0, m_min = '1, m_max = '0, m_total = '0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endfunction

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) cyc <= cyc + 1;

    initial begin : kernel
        bit kr, kd, krst;
        int kc;
        done_drv = 1'b0;
        forever begin
            @(negedge ap_clk);
            kr   = (dut_ap_start === 1'b1) && (dut_ap_ready === 1'b1);
            kd   = (done_drv === 1'b1) && (dut_ap_continue === 1'b1);
            krst = (ap_rst_n !== 1'b1);
            kc   = cyc;
            @(posedge ap_clk);
            #1;
            if (krst) kq.delete();
            else begin
                if (kd && kq.size() > 0) void'(kq.pop_front());
                if (kr) kq.push_back(kc + klat);
            end
            done_drv = 1'b0;
            if (kq.size() > 0) done_drv = (kq[0] <= cyc) && (cyc >= withhold_until);
        end
    end

    initial begin : compare
        int k;
        int st;
        logic [31:0] latv;
        bit d, e_start, e_cont, e_rd;
        forever begin
            @(negedge ap_clk);
            if (mon_en) begin
                k = cyc;
                d = done_drv;
                if (m_active != 0 && d && m_ack == 0) begin
                    m_ack = 1;
                    m_done_first = k;
                end
                e_cont  = (m_active != 0) && d && (m_ack != 0) && (k >= m_done_first + m_hold);
                e_start = (m_active != 0) && (m_issued < m_num) && (k >= m_earliest) &&
                          (m_pending != 0 || stq.size() < MAX_OUT);
                e_rd    = (k == m_rd);
                chk("busy", busy, m_active);
                chk("ap_start", dut_ap_start, e_start);
                chk("ap_continue", dut_ap_continue, e_cont);
                chk("run_done", run_done, e_rd);
                chk("txn_issued", txn_issued, m_issued);
                chk("txn_completed", txn_completed, m_completed);
                chk("last_latency", last_latency, m_last);
                chk("min_latency", min_latency, m_min);
                chk("max_latency", max_latency, m_max);
                chk("total_cycles", total_cycles, m_total);
                if (dut_ap_start === 1'b1) n_start_cyc++;
                if (dut_ap_continue === 1'b1) n_cont_cyc++;
                if (run_done === 1'b1) n_rd++;
                if (!ap_rst_n) begin
                    m_active = 0; m_issued = 0; m_completed = 0; m_pending = 0;
                    m_ack = 0; m_rd = -1; m_num = 0; m_gap = 0; m_hold = 0;
                    stq.delete();
                    m_last = '0; m_min = '1; m_max = '0; m_total = '0;
                end else begin
                    if (e_start && m_pending == 0) begin
                        stq.push_back(k);
                        m_pending = 1;
                    end
                    if (e_start) begin
                        m_issued++;
                        m_pending = 0;
                        m_earliest = k + m_gap + 1;
                    end
                    if (e_cont) begin
                        m_ack = 0;
                        m_completed++;
                        if (stq.size() > 0) begin
                            st = stq.pop_front();
                            latv = 32'(k - st);
                            m_last = latv;
                            if (latv < m_min) m_min = latv;
                            if (latv > m_max) m_max = latv;
                        end
                        if (m_completed == m_num) m_rd = k + 2;
                    end
                    if (cfg_start && m_active == 0) begin
                        m_num = int'(cfg_num_txn); m_gap = int'(cfg_gap); m_hold = int'(cfg_cont_hold);
                        m_issued = 0; m_completed = 0; m_pending = 0; m_ack = 0;
                        stq.delete();
                        m_last = '0; m_min = '1; m_max = '0; m_total = '0;
                        m_start_cyc = k;
                        m_earliest = k + 1;
                        if (m_num == 0) m_rd = k + 1;
                        else m_active = 1;
                    end
                    if (k + 1 == m_rd) begin
                        m_active = 0;
                        m_total = 32'(m_rd - m_start_cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic run(input int num, input int gap, input int hold, input int lat, input int whold, input bit poke);
        bit got;
        klat = lat;
        withhold_until = cyc + whold;
        cfg_num_txn = 16'(num);
        cfg_gap = 8'(gap);
        cfg_cont_hold = 8'(hold);
        cfg_start = 1'b1;
        n_start_cyc = 0;
        n_cont_cyc = 0;
        n_rd = 0;
        tick();
        cfg_start = 1'b0;
        if (poke) begin
            repeat (3) tick();
            cfg_num_txn = 16'd1;
            cfg_gap = 8'd0;
            cfg_cont_hold = 8'd9;
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge ap_clk);
            if (run_done === 1'b1) got = 1;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL run_done_wait: actual none, expected a pulse within 3000 cycles");
        end
        repeat (3) tick();
    endtask

    initial begin : stim
        ap_rst_n = 1'b0;
        cfg_start = 1'b0;
        cfg_num_txn = '0;
        cfg_gap = '0;
        cfg_cont_hold = '0;
        tick();
        mon_en = 1;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", dut_ap_start, 0);
        chk("rst_min", min_latency, 32'hFFFF_FFFF);
        chk("rst_total", total_cycles, 0);
        ap_rst_n = 1'b1;
        repeat (2) tick();

        // single transaction, 5-cycle kernel
        run(1, 0, 0, 5, 0, 0);
        chk("t1_last", last_latency, 5);
        chk("t1_min", min_latency, 5);
        chk("t1_max", max_latency, 5);
        chk("t1_issued", txn_issued, 1);
        chk("t1_done", txn_completed, 1);
        chk("t1_total", total_cycles, 8);
        chk("t1_starts", n_start_cyc, 1);
        chk("t1_rd_pulses", n_rd, 1);

        // four transactions, gap 3, 10-cycle kernel, ignored cfg_start mid-run
        run(4, 3, 0, 10, 0, 1);
        chk("t2_min", min_latency, 10);
        chk("t2_max", max_latency, 10);
        chk("t2_done", txn_completed, 4);
        chk("t2_total", total_cycles, 25);
        chk("t2_starts", n_start_cyc, 4);
        chk("t2_rd_pulses", n_rd, 1);

        // outstanding limit: done withheld until 41 cycles after cfg_start
        run(8, 0, 0, 1, 41, 0);
        chk("t3_max", max_latency, 40);
        chk("t3_min", min_latency, 3);
        chk("t3_issued", txn_issued, 8);
        chk("t3_done", txn_completed, 8);
        chk("t3_total", total_cycles, 50);
        chk("t3_starts", n_start_cyc, 8);

        // continue held off 7 cycles after a 6-cycle kernel
        run(1, 0, 7, 6, 0, 0);
        chk("t4_last", last_latency, 13);
        chk("t4_total", total_cycles, 16);
        chk("t4_conts", n_cont_cyc, 1);

        // empty run
        run(0, 2, 2, 5, 0, 0);
        chk("t5_min", min_latency, 32'hFFFF_FFFF);
        chk("t5_total", total_cycles, 1);
        chk("t5_starts", n_start_cyc, 0);
        chk("t5_rd_pulses", n_rd, 1);
        chk("t5_issued", txn_issued, 0);

        // reset while a start is being driven, then a clean run
        klat = 20;
        withhold_until = 0;
        cfg_num_txn = 16'd4;
        cfg_gap = 8'd0;
        cfg_cont_hold = 8'd0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        chk("t6_start_before_rst", dut_ap_start, 1);
        ap_rst_n = 1'b0;
        tick();
        chk("t6_rst_start", dut_ap_start, 0);
        chk("t6_rst_cont", dut_ap_continue, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_issued", txn_issued, 0);
        chk("t6_rst_min", min_latency, 32'hFFFF_FFFF);
        ap_rst_n = 1'b1;
        tick();
        run(2, 1, 2, 4, 0, 0);
        chk("t6_min", min_latency, 6);
        chk("t6_max", max_latency, 7);
        chk("t6_last", last_latency, 7);
        chk("t6_done", txn_completed, 2);
        chk("t6_total", total_cycles, 12);
        chk("t6_rd_pulses", n_rd, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
